// File: rtl/serial_fto_sequencer.sv
// serial_fto_sequencer: bit-serial add/sub controller that drives a 1-bit full-add/full-sub mux stage.
// Optional feature macro FTO_SELFCHECK_EN adds a parallel reference adder and a sticky chk_err output.
module serial_fto_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             fto_in1,
    output logic             fto_in2,
    output logic             fto_in3,
    output logic [1:0]       fto_sel,
    input  logic             fto_out
`ifdef FTO_SELFCHECK_EN
    ,
    output logic             chk_err
`endif
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] LOW  = 2'b01;
    localparam logic [1:0] HIGH = 2'b10;
    localparam logic [1:0] DONE = 2'b11;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [CW-1:0]    cnt;
    logic             cy;
    logic             op;

    // FSM: LOW phase captures the sum/difference bit, HIGH phase captures carry/borrow and advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            r_sh      <= '0;
            cnt       <= '0;
            cy        <= 1'b0;
            op        <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sh  <= opa;
                    b_sh  <= opb;
                    op    <= op_sub;
                    cy    <= 1'b0;
                    cnt   <= '0;
                    state <= LOW;
                end
                LOW: begin
                    r_sh  <= {fto_out, r_sh[WIDTH-1:1]};
                    state <= HIGH;
                end
                HIGH: begin
                    cy   <= fto_out;
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        result    <= r_sh;
                        carry_out <= fto_out;
                        state     <= DONE;
                    end else begin
                        state <= LOW;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Mux-stage drive is gated to zero outside LOW/HIGH so idle and done cycles present a quiet stage
    always_comb begin
        busy    = (state == LOW) || (state == HIGH);
        done    = state == DONE;
        fto_in1 = busy & a_sh[0];
        fto_in2 = busy & b_sh[0];
        fto_in3 = busy & cy;
        fto_sel = busy ? {op, state == HIGH} : 2'b00;
    end

`ifdef FTO_SELFCHECK_EN
    logic [WIDTH:0] exp_sum;

    // Reference result computed in parallel at acceptance, compared when the serial result lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_sum <= '0;
            chk_err <= 1'b0;
        end else begin
            if (state == IDLE && start)
                exp_sum <= op_sub ? {1'b0, opa} - {1'b0, opb} : {1'b0, opa} + {1'b0, opb};
            if (state == DONE && {carry_out, result} != exp_sum)
                chk_err <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_serial_fto_sequencer.sv
// tb_serial_fto_sequencer: table-driven scoreboard bench with a behavioural full-add/full-sub mux stage.
module tb_serial_fto_sequencer;
    typedef struct {
        logic       s;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       c;
    } vec_t;

    logic       clk, rst_n, start, op_sub, flip;
    logic [7:0] opa, opb, result;
    logic       busy, done, carry_out, fto_in1, fto_in2, fto_in3, fto_out;
    logic [1:0] fto_sel;
`ifdef FTO_SELFCHECK_EN
    logic       chk_err;
`endif
    int         tests, fails;
    logic [8:0] sb[$];
    vec_t       vt[8];

    serial_fto_sequencer #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .opa(opa), .opb(opb),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out),
        .fto_in1(fto_in1), .fto_in2(fto_in2), .fto_in3(fto_in3), .fto_sel(fto_sel),
        .fto_out(fto_out)
`ifdef FTO_SELFCHECK_EN
        , .chk_err(chk_err)
`endif
    );

    logic sum_bit, cout_bit, bout_bit;
    assign sum_bit  = fto_in1 ^ fto_in2 ^ fto_in3;
    assign cout_bit = (fto_in1 & fto_in2) | (fto_in3 & (fto_in1 | fto_in2));
    assign bout_bit = (~fto_in1 & (fto_in2 | fto_in3)) | (fto_in2 & fto_in3);
    assign fto_out  = flip ^ (fto_sel[0] ? (fto_sel[1] ? bout_bit : cout_bit) : sum_bit);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic s, input logic [7:0] a, input logic [7:0] b,
                          input logic [8:0] expv, input bit poke, input bit chk_on);
        int         cyc, bad, i;
        logic       bc;
        logic [8:0] e;
        @(negedge clk);
        start = 1'b1; op_sub = s; opa = a; opb = b;
        if (chk_on) sb.push_back(expv);
        @(negedge clk);
        start = 1'b0; opa = ~a; opb = 8'h5A; op_sub = ~s;
        cyc = 0; bad = 0; bc = 1'b0;
        while (!done && cyc < 40) begin
            i = cyc / 2;
            if (cyc >= 16) bad++;
            else if (busy !== 1'b1 || fto_sel !== {s, cyc[0]} || fto_in1 !== a[i] ||
                     fto_in2 !== b[i] || fto_in3 !== bc) bad++;
            if (cyc % 2 == 1 && cyc < 16)
                bc = s ? ((~a[i] & (b[i] | bc)) | (b[i] & bc)) : ((a[i] & b[i]) | (bc & (a[i] | b[i])));
            if (poke && cyc == 4) begin
                start = 1'b1; opa = 8'hC3; opb = 8'h11;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        if (chk_on) begin
            chk("latency", cyc, 16);
            chk("bit_stream", bad, 0);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("result", {carry_out, result}, e);
            end
        end
        if (poke) begin
            start = 1'b1; opa = 8'h77; opb = 8'h22;
        end
        @(negedge clk);
        start = 1'b0;
        if (chk_on) begin
            chk("done_pulse", done, 0);
            chk("busy_after", busy, 0);
            chk("hold", {carry_out, result}, expv);
        end
    endtask

    initial begin
        int n;
        tests = 0; fails = 0;
        rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; opa = '0; opb = '0; flip = 1'b0;
        vt[0] = '{1'b0, 8'h3C, 8'h05, 8'h41, 1'b0};
        vt[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1};
        vt[2] = '{1'b1, 8'h05, 8'h03, 8'h02, 1'b0};
        vt[3] = '{1'b1, 8'h03, 8'h05, 8'hFE, 1'b1};
        vt[4] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1};
        vt[5] = '{1'b1, 8'hAA, 8'h55, 8'h55, 1'b0};
        vt[6] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b1};
        vt[7] = '{1'b0, 8'h10, 8'h20, 8'h30, 1'b0};
        repeat (3) @(negedge clk);
        chk("reset_outs", {busy, done, result, carry_out, fto_in1, fto_in2, fto_in3, fto_sel}, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            run_op(vt[k].s, vt[k].a, vt[k].b, {vt[k].c, vt[k].r}, 1'b0, 1'b1);
`ifdef FTO_SELFCHECK_EN
            chk("chk_err_clean", chk_err, 0);
`endif
        end
        run_op(1'b0, 8'h12, 8'h34, 9'h046, 1'b1, 1'b1);
        @(negedge clk);
        start = 1'b1; op_sub = 1'b0; opa = 8'h3C; opb = 8'h05;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("busy_before_abort", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_outs", {busy, done, result, carry_out, fto_in1, fto_in2, fto_in3, fto_sel}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("no_done_after_abort", n, 0);
        run_op(1'b0, 8'h10, 8'h20, 9'h030, 1'b0, 1'b1);
`ifdef FTO_SELFCHECK_EN
        flip = 1'b1;
        run_op(1'b1, 8'h03, 8'h05, 9'h000, 1'b0, 1'b0);
        flip = 1'b0;
        chk("chk_err_set", chk_err, 1);
        run_op(1'b0, 8'h01, 8'h01, 9'h002, 1'b0, 1'b1);
        chk("chk_err_sticky", chk_err, 1);
        rst_n = 1'b0;
        #1;
        chk("chk_err_reset", chk_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
